// File: rtl/id_ex_stage_pkg.sv
// Shared CPU definitions: ALU op codes, forwarding selects and datapath widths.
// Pure declarations, no timing.
package cpu_defs;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_MUL = 3'b100,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Operand forwarding select for rs/rt: combinational, zero latency, no backpressure.
// The younger EX/MEM result wins over MEM/WB; register 0 is never forwarded.
module forward_unit
    import cpu_defs::*;
#(
    parameter int REG_AW = cpu_defs::REG_AW
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd_addr,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd_addr,
    output fwd_sel_t          fwd_rs,
    output fwd_sel_t          fwd_rt
);

    logic rs_nz;
    logic rt_nz;

    assign rs_nz = (rs_addr != '0);
    assign rt_nz = (rt_addr != '0);

    always_comb begin
        fwd_rs = FWD_RF;
        if (rs_nz && exmem_reg_write && (exmem_rd_addr == rs_addr)) begin
            fwd_rs = FWD_EXMEM;
        end else if (rs_nz && memwb_reg_write && (memwb_rd_addr == rs_addr)) begin
            fwd_rs = FWD_MEMWB;
        end
    end

    always_comb begin
        fwd_rt = FWD_RF;
        if (rt_nz && exmem_reg_write && (exmem_rd_addr == rt_addr)) begin
            fwd_rt = FWD_EXMEM;
        end else if (rt_nz && memwb_reg_write && (memwb_rd_addr == rt_addr)) begin
            fwd_rt = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding and load-use bubble insertion.
// 1 cycle ID->outputs; stall_i holds everything, hazard_o tells ID/PC to hold.
module id_ex_stage
    import cpu_defs::*;
#(
    parameter int DATA_W = cpu_defs::DATA_W,
    parameter int REG_AW = cpu_defs::REG_AW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] RSdata_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [REG_AW-1:0] RSaddr_i,
    input  logic [REG_AW-1:0] RTaddr_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    input  logic [2:0]        ALUControl_i,
    input  logic              ALUSrc_i,
    input  logic              RegDst_i,
    input  logic              RegWrite_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              MemtoReg_i,
    input  logic              EXMEM_RegWrite_i,
    input  logic [REG_AW-1:0] EXMEM_RDaddr_i,
    input  logic [DATA_W-1:0] EXMEM_data_i,
    input  logic              MEMWB_RegWrite_i,
    input  logic [REG_AW-1:0] MEMWB_RDaddr_i,
    input  logic [DATA_W-1:0] MEMWB_data_i,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic [2:0]        ALUControl_o,
    output logic [DATA_W-1:0] STdata_o,
    output logic [REG_AW-1:0] WBaddr_o,
    output logic              RegWrite_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              MemtoReg_o,
    output logic              valid_o,
    output logic              hazard_o
);

    typedef struct packed {
        logic              valid;
        ctrl_t             ctrl;
        alu_op_t           alu_op;
        logic              alu_src;
        logic [REG_AW-1:0] wb_addr;
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
    } stage_t;

    stage_t   stage_q;
    stage_t   load_d;
    fwd_sel_t fwd_rs;
    fwd_sel_t fwd_rt;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic              wb_hit;

    always_comb begin
        load_d                 = '0;
        load_d.valid           = valid_i;
        load_d.ctrl.reg_write  = RegWrite_i;
        load_d.ctrl.mem_read   = MemRead_i;
        load_d.ctrl.mem_write  = MemWrite_i;
        load_d.ctrl.mem_to_reg = MemtoReg_i;
        load_d.alu_op          = alu_op_t'(ALUControl_i);
        load_d.alu_src         = ALUSrc_i;
        load_d.wb_addr         = RegDst_i ? RDaddr_i : RTaddr_i;
        load_d.rs_addr         = RSaddr_i;
        load_d.rt_addr         = RTaddr_i;
        load_d.rs_data         = RSdata_i;
        load_d.rt_data         = RTdata_i;
        load_d.imm             = imm_i;
    end

    // A load in EX whose destination is read by the instruction in ID cannot be
    // forwarded in time; a stall already freezes ID, so no hazard is reported then.
    assign wb_hit   = (stage_q.wb_addr == RSaddr_i) || (stage_q.wb_addr == RTaddr_i);
    assign hazard_o = !stall_i && stage_q.valid && stage_q.ctrl.mem_read
                      && (stage_q.wb_addr != '0) && valid_i && wb_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else if (flush_i) begin
            stage_q <= '0;
        end else if (stall_i) begin
            stage_q <= stage_q;
        end else if (hazard_o) begin
            stage_q <= '0;
        end else begin
            stage_q <= load_d;
        end
    end

    forward_unit #(
        .REG_AW (REG_AW)
    ) u_forward_unit (
        .rs_addr         (stage_q.rs_addr),
        .rt_addr         (stage_q.rt_addr),
        .exmem_reg_write (EXMEM_RegWrite_i),
        .exmem_rd_addr   (EXMEM_RDaddr_i),
        .memwb_reg_write (MEMWB_RegWrite_i),
        .memwb_rd_addr   (MEMWB_RDaddr_i),
        .fwd_rs          (fwd_rs),
        .fwd_rt          (fwd_rt)
    );

    always_comb begin
        case (fwd_rs)
            FWD_EXMEM: rs_fwd = EXMEM_data_i;
            FWD_MEMWB: rs_fwd = MEMWB_data_i;
            default:   rs_fwd = stage_q.rs_data;
        endcase
    end

    always_comb begin
        case (fwd_rt)
            FWD_EXMEM: rt_fwd = EXMEM_data_i;
            FWD_MEMWB: rt_fwd = MEMWB_data_i;
            default:   rt_fwd = stage_q.rt_data;
        endcase
    end

    assign data1_o      = rs_fwd;
    assign data2_o      = stage_q.alu_src ? stage_q.imm : rt_fwd;
    assign STdata_o     = rt_fwd;
    assign ALUControl_o = stage_q.alu_op;
    assign WBaddr_o     = stage_q.wb_addr;
    assign RegWrite_o   = stage_q.ctrl.reg_write;
    assign MemRead_o    = stage_q.ctrl.mem_read;
    assign MemWrite_o   = stage_q.ctrl.mem_write;
    assign MemtoReg_o   = stage_q.ctrl.mem_to_reg;
    assign valid_o      = stage_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table through a scoreboard queue, plus reset sequences.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, flush_i, valid_i;
    logic [31:0] RSdata_i, RTdata_i, imm_i;
    logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
    logic [2:0]  ALUControl_i;
    logic        ALUSrc_i, RegDst_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i;
    logic        EXMEM_RegWrite_i, MEMWB_RegWrite_i;
    logic [4:0]  EXMEM_RDaddr_i, MEMWB_RDaddr_i;
    logic [31:0] EXMEM_data_i, MEMWB_data_i;
    logic [31:0] data1_o, data2_o, STdata_o;
    logic [2:0]  ALUControl_o;
    logic [4:0]  WBaddr_o;
    logic        RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, valid_o, hazard_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    id_ex_stage dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .valid_i          (valid_i),
        .RSdata_i         (RSdata_i),
        .RTdata_i         (RTdata_i),
        .imm_i            (imm_i),
        .RSaddr_i         (RSaddr_i),
        .RTaddr_i         (RTaddr_i),
        .RDaddr_i         (RDaddr_i),
        .ALUControl_i     (ALUControl_i),
        .ALUSrc_i         (ALUSrc_i),
        .RegDst_i         (RegDst_i),
        .RegWrite_i       (RegWrite_i),
        .MemRead_i        (MemRead_i),
        .MemWrite_i       (MemWrite_i),
        .MemtoReg_i       (MemtoReg_i),
        .EXMEM_RegWrite_i (EXMEM_RegWrite_i),
        .EXMEM_RDaddr_i   (EXMEM_RDaddr_i),
        .EXMEM_data_i     (EXMEM_data_i),
        .MEMWB_RegWrite_i (MEMWB_RegWrite_i),
        .MEMWB_RDaddr_i   (MEMWB_RDaddr_i),
        .MEMWB_data_i     (MEMWB_data_i),
        .data1_o          (data1_o),
        .data2_o          (data2_o),
        .ALUControl_o     (ALUControl_o),
        .STdata_o         (STdata_o),
        .WBaddr_o         (WBaddr_o),
        .RegWrite_o       (RegWrite_o),
        .MemRead_o        (MemRead_o),
        .MemWrite_o       (MemWrite_o),
        .MemtoReg_o       (MemtoReg_o),
        .valid_o          (valid_o),
        .hazard_o         (hazard_o)
    );

    typedef struct packed {
        logic        stall, flush, valid;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
        logic [2:0]  alu;
        logic        src, dst, rw, mr, mw, mtr;
        logic        ex_we;
        logic [4:0]  ex_rd;
        logic [31:0] ex_data;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        e_haz, e_valid, e_rw, e_mr, e_mw, e_mtr;
        logic [2:0]  e_alu;
        logic [4:0]  e_wb;
        logic [31:0] e_d1, e_d2, e_st;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t ins(input int v, input int rsd, input int rtd, input int im,
                                 input int rs, input int rt, input int rd, input int alu,
                                 input int src, input int dst, input int rw, input int mr,
                                 input int mw, input int mtr);
        vec_t t;
        t = '0;
        t.valid = v[0];    t.rs_data = rsd;  t.rt_data = rtd; t.imm = im;
        t.rs = rs[4:0];    t.rt = rt[4:0];   t.rd = rd[4:0];  t.alu = alu[2:0];
        t.src = src[0];    t.dst = dst[0];   t.rw = rw[0];    t.mr = mr[0];
        t.mw = mw[0];      t.mtr = mtr[0];
        return t;
    endfunction

    function automatic vec_t fw(input vec_t t, input int ew, input int erd, input int ed,
                                input int ww, input int wrd, input int wd);
        vec_t r;
        r = t;
        r.ex_we = ew[0]; r.ex_rd = erd[4:0]; r.ex_data = ed;
        r.wb_we = ww[0]; r.wb_rd = wrd[4:0]; r.wb_data = wd;
        return r;
    endfunction

    function automatic vec_t ctl(input vec_t t, input int st, input int fl);
        vec_t r;
        r = t;
        r.stall = st[0];
        r.flush = fl[0];
        return r;
    endfunction

    function automatic vec_t ex(input vec_t t, input int haz, input int v, input int rw,
                                input int mr, input int mw, input int mtr, input int alu,
                                input int wb, input int d1, input int d2, input int st);
        vec_t r;
        r = t;
        r.e_haz = haz[0]; r.e_valid = v[0]; r.e_rw = rw[0]; r.e_mr = mr[0];
        r.e_mw = mw[0];   r.e_mtr = mtr[0]; r.e_alu = alu[2:0]; r.e_wb = wb[4:0];
        r.e_d1 = d1;      r.e_d2 = d2;      r.e_st = st;
        return r;
    endfunction

    function automatic vec_t bub(input vec_t t, input int haz);
        return ex(t, haz, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, req);
        end
    endtask

    task automatic apply(input vec_t t);
        stall_i = t.stall;   flush_i = t.flush;     valid_i = t.valid;
        RSdata_i = t.rs_data; RTdata_i = t.rt_data; imm_i = t.imm;
        RSaddr_i = t.rs;     RTaddr_i = t.rt;       RDaddr_i = t.rd;
        ALUControl_i = t.alu; ALUSrc_i = t.src;     RegDst_i = t.dst;
        RegWrite_i = t.rw;   MemRead_i = t.mr;      MemWrite_i = t.mw; MemtoReg_i = t.mtr;
        EXMEM_RegWrite_i = t.ex_we; EXMEM_RDaddr_i = t.ex_rd; EXMEM_data_i = t.ex_data;
        MEMWB_RegWrite_i = t.wb_we; MEMWB_RDaddr_i = t.wb_rd; MEMWB_data_i = t.wb_data;
    endtask

    task automatic compare_out(input int idx, input vec_t e);
        chk("valid_o",      idx, 32'(valid_o),      32'(e.e_valid));
        chk("RegWrite_o",   idx, 32'(RegWrite_o),   32'(e.e_rw));
        chk("MemRead_o",    idx, 32'(MemRead_o),    32'(e.e_mr));
        chk("MemWrite_o",   idx, 32'(MemWrite_o),   32'(e.e_mw));
        chk("MemtoReg_o",   idx, 32'(MemtoReg_o),   32'(e.e_mtr));
        chk("ALUControl_o", idx, 32'(ALUControl_o), 32'(e.e_alu));
        chk("WBaddr_o",     idx, 32'(WBaddr_o),     32'(e.e_wb));
        chk("data1_o",      idx, data1_o,           e.e_d1);
        chk("data2_o",      idx, data2_o,           e.e_d2);
        chk("STdata_o",     idx, STdata_o,          e.e_st);
    endtask

    task automatic check_zero(input string tag, input int idx);
        vec_t z;
        z = '0;
        chk({tag, "_hazard"}, idx, 32'(hazard_o), 32'(0));
        compare_out(idx, z);
    endtask

    initial begin
        vec_t t;
        vec_t lw;
        vec_t dep;
        vec_t e;

        // Operand-level fixtures reused across several vectors.
        lw  = ins(1, 'h1000, 'h77, 8, 1, 2, 0, 2, 1, 0, 1, 1, 0, 1);
        dep = ins(1, 'h11, 'h22, 0, 2, 3, 4, 1, 0, 1, 1, 0, 0, 0);

        tbl.push_back(ex(ins(1, 5, 'h22, 'h10, 1, 2, 3, 2, 1, 1, 1, 0, 0, 0),
                         0, 1, 1, 0, 0, 0, 2, 3, 5, 'h10, 'h22));
        tbl.push_back(ex(fw(ins(1, 'h100, 'h200, 0, 4, 5, 8, 0, 0, 0, 1, 0, 0, 0), 1, 4, 7, 1, 4, 9),
                         0, 1, 1, 0, 0, 0, 0, 5, 7, 'h200, 'h200));
        tbl.push_back(ex(fw(ins(1, 'h100, 'h200, 0, 4, 4, 6, 0, 0, 1, 1, 0, 0, 0), 0, 4, 7, 1, 4, 9),
                         0, 1, 1, 0, 0, 0, 0, 6, 9, 9, 9));
        tbl.push_back(ex(fw(ins(1, 'h55, 'h66, 0, 0, 0, 7, 6, 0, 1, 1, 0, 0, 0), 1, 0, 7, 1, 0, 9),
                         0, 1, 1, 0, 0, 0, 6, 7, 'h55, 'h66, 'h66));
        tbl.push_back(ex(lw, 0, 1, 1, 1, 0, 1, 2, 2, 'h1000, 8, 'h77));
        tbl.push_back(bub(dep, 1));
        tbl.push_back(ex(fw(dep, 0, 0, 0, 1, 2, 'hAB), 0, 1, 1, 0, 0, 0, 1, 4, 'hAB, 'h22, 'h22));
        tbl.push_back(ex(lw, 0, 1, 1, 1, 0, 1, 2, 2, 'h1000, 8, 'h77));
        tbl.push_back(ex(ctl(dep, 1, 0), 0, 1, 1, 1, 0, 1, 2, 2, 'h1000, 8, 'h77));
        tbl.push_back(bub(dep, 1));
        tbl.push_back(ex(ins(1, 'h31, 'h32, 0, 1, 3, 9, 7, 0, 1, 1, 0, 0, 0),
                         0, 1, 1, 0, 0, 0, 7, 9, 'h31, 'h32, 'h32));
        tbl.push_back(bub(ctl(ins(1, 'h99, 'h98, 0, 1, 2, 3, 2, 0, 1, 1, 0, 1, 0), 1, 1), 0));
        tbl.push_back(ex(ins(1, 'h41, 'h42, 'h43, 5, 6, 10, 4, 1, 1, 1, 0, 1, 0),
                         0, 1, 1, 0, 1, 0, 4, 10, 'h41, 'h43, 'h42));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(ex(ctl(ins(1, 'hDEAD + k, 'hBEEF, 1, 7, 8, 11, 6, 0, 1, 0, 1, 0, 1), 1, 0),
                             0, 1, 1, 0, 1, 0, 4, 10, 'h41, 'h43, 'h42));
        end
        tbl.push_back(ex(ins(1, 'h2000, 5, 4, 1, 2, 0, 2, 1, 0, 1, 1, 0, 1),
                         0, 1, 1, 1, 0, 1, 2, 2, 'h2000, 4, 5));
        t = ins(1, 'h11, 'h22, 0, 3, 2, 4, 1, 0, 1, 1, 0, 0, 0);
        tbl.push_back(bub(ctl(t, 0, 1), 1));
        tbl.push_back(ex(t, 0, 1, 1, 0, 0, 0, 1, 4, 'h11, 'h22, 'h22));
        tbl.push_back(ex(ins(1, 'h3000, 6, 4, 1, 0, 5, 2, 1, 0, 1, 1, 0, 1),
                         0, 1, 1, 1, 0, 1, 2, 0, 'h3000, 4, 6));
        tbl.push_back(ex(ins(1, 7, 8, 0, 0, 0, 4, 0, 0, 1, 1, 0, 0, 0),
                         0, 1, 1, 0, 0, 0, 0, 4, 7, 8, 8));

        t = '0;
        apply(t);
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_zero("reset", 0);
        rst_i = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk_i);
            apply(tbl[i]);
            #1;
            chk("hazard_o", i, 32'(hazard_o), 32'(tbl[i].e_haz));
            exp_q.push_back(tbl[i]);
            @(posedge clk_i);
            #1;
            e = exp_q.pop_front();
            compare_out(i, e);
        end

        // Asynchronous reset while stalled with a live instruction in the stage.
        @(negedge clk_i);
        t = ctl(ins(1, 'h5A, 'h5B, 0, 1, 2, 3, 2, 0, 1, 1, 1, 0, 0), 1, 0);
        apply(t);
        #1;
        chk("pre_rst_valid", 0, 32'(valid_o), 32'(1));
        rst_i = 1'b1;
        #1;
        check_zero("async_rst", 1);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_zero("post_rst_stall", 2);

        // Leaving the stall loads normally; nothing pending survived reset.
        @(negedge clk_i);
        apply(ctl(t, 0, 0));
        @(posedge clk_i);
        #1;
        compare_out(100, ex(t, 0, 1, 1, 1, 0, 0, 2, 3, 'h5A, 'h5B, 'h5B));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
